seq_divider_8by4: RTL

SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

---
 rtl/divider_pkg.sv | 18 +
 rtl/seq_divider_8by4_if.sv | 31 +++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider_8by4.sv | 105 ++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential 8-by-4 divider.
// Holds the default operand widths, the iteration count, the quotient value
// reported on a divide by zero, and the controller state encoding.
package divider_pkg;

    localparam int unsigned DVD_W_DEF = 8;
    localparam int unsigned DVS_W_DEF = 4;
    localparam int unsigned ITERS     = DVD_W_DEF;

    localparam logic [DVD_W_DEF-1:0] DBZ_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Request/result bundle of the sequential divider.
// master (requester): drives start, dividend, divisor; sees the results.
// slave  (divider)  : receives the request; drives quotient, remainder,
//                     busy, done, div_by_zero.
interface seq_divider_8by4_if
    import divider_pkg::*;
#(
    parameter int unsigned DVD_W = DVD_W_DEF,
    parameter int unsigned DVS_W = DVS_W_DEF
);

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One unsigned restoring-division iteration (purely combinational).
// Ports:
//   i_prem : current partial remainder (DVS_W+1 bits)
//   i_bit  : next dividend bit, shifted in as the new LSB
//   i_dvs  : divisor
//   o_prem : partial remainder after the conditional subtract
//   o_qbit : quotient bit produced by this iteration
module div_step #(
    parameter int unsigned DVS_W = 4
) (
    input  logic [DVS_W:0]   i_prem,
    input  logic             i_bit,
    input  logic [DVS_W-1:0] i_dvs,
    output logic [DVS_W:0]   o_prem,
    output logic             o_qbit
);

    localparam int unsigned SHW = DVS_W + 2;

    logic [SHW-1:0] w_shift;
    logic [SHW-1:0] w_dvs_ext;
    logic [SHW-1:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in DVS_W+1 bits; the extra bit only keeps the arithmetic obviously safe.
    assign w_shift   = {i_prem, i_bit};
    assign w_dvs_ext = SHW'(i_dvs);
    assign w_diff    = w_shift - w_dvs_ext;
    assign o_qbit    = (w_shift >= w_dvs_ext);
    assign o_prem    = o_qbit ? (DVS_W+1)'(w_diff) : (DVS_W+1)'(w_shift);

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential unsigned divider: DVD_W-bit dividend by DVS_W-bit divisor,
// one restoring iteration per clock, results registered and held until the
// next completion.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_divider_8by4_if (start/dividend/divisor in,
//           quotient/remainder/busy/done/div_by_zero out)
module seq_divider_8by4
    import divider_pkg::*;
#(
    parameter int unsigned DVD_W = DVD_W_DEF,
    parameter int unsigned DVS_W = DVS_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_8by4_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(ITERS);

    state_e           r_state;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W:0]   r_prem;
    logic [CNT_W-1:0] r_cnt;
    logic [DVD_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [DVS_W:0]   w_prem;
    logic             w_qbit;

    div_step #(.DVS_W(DVS_W)) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[DVD_W-1]),
        .i_dvs  (r_dvs),
        .o_prem (w_prem),
        .o_qbit (w_qbit)
    );

    // Controller and datapath. r_dvd doubles as the quotient accumulator:
    // each iteration consumes its MSB and shifts the new quotient bit into its LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_dvd  <= bus.dividend;
                        r_dvs  <= bus.divisor;
                        r_prem <= '0;
                        r_cnt  <= '0;
                        if (bus.divisor == '0) begin
                            r_quot  <= DVD_W'(DBZ_QUOT);
                            r_rem   <= '0;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_CALC;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_dvd  <= {r_dvd[DVD_W-2:0], w_qbit};
                    r_prem <= w_prem;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(ITERS - 1)) begin
                        r_quot  <= {r_dvd[DVD_W-2:0], w_qbit};
                        r_rem   <= w_prem[DVS_W-1:0];
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule
